if_stage_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. Holds the PC, fetches from instruction memory over a ready/valid handshake, and freezes on the ID-stage `hazard_detected` signal (load-use and branch-operand stalls). Redirects on a branch resolved in ID and flushes the wrong-path instruction. Presents the fetched instruction and PC+4 to the ID stage, and keeps saturating stall/flush counters for performance monitoring.

---
 rtl/if_stage_unit.sv | 111 +++++++++++
 tb/tb_if_stage_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, single-entry skid buffer for freezes,
// branch redirect/flush and saturating stall/flush performance counters.
module if_stage_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_detected,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus4,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [0:0] {StFetch, StHeld} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] skid_q;
    logic [INSTR_W-1:0] if_id_instr_q;
    logic [ADDR_W-1:0]  if_id_pc_plus4_q;
    logic               if_id_valid_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;

    logic              freeze;
    logic              redirect;
    logic              xfer;
    logic [ADDR_W-1:0] pc_plus4;

    // Branch operands are not ready while a hazard is flagged, so the branch is ignored.
    assign freeze   = hazard_detected;
    assign redirect = branch_taken & ~hazard_detected;
    assign imem_req = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign xfer     = imem_req & imem_ready;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StFetch;
            pc_q             <= RESET_PC;
            skid_q           <= '0;
            if_id_instr_q    <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_valid_q    <= 1'b0;
            stall_cnt_q      <= '0;
            flush_cnt_q      <= '0;
        end else begin
            if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            if (redirect) begin
                // Wrong-path instruction and any skid contents are dropped.
                pc_q          <= {branch_target[ADDR_W-1:2], 2'b00};
                if_id_instr_q <= '0;
                if_id_valid_q <= 1'b0;
                skid_q        <= '0;
                state_q       <= StFetch;
                if (flush_cnt_q != {CNT_W{1'b1}}) begin
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                end
            end else begin
                unique case (state_q)
                    StFetch: begin
                        if (xfer && !freeze) begin
                            if_id_instr_q    <= imem_rdata;
                            if_id_pc_plus4_q <= pc_plus4;
                            if_id_valid_q    <= 1'b1;
                            pc_q             <= pc_plus4;
                        end else if (xfer && freeze) begin
                            skid_q  <= imem_rdata;
                            state_q <= StHeld;
                        end else if (!freeze) begin
                            if_id_instr_q <= '0;
                            if_id_valid_q <= 1'b0;
                        end
                    end
                    StHeld: begin
                        if (!freeze) begin
                            if_id_instr_q    <= skid_q;
                            if_id_pc_plus4_q <= pc_plus4;
                            if_id_valid_q    <= 1'b1;
                            pc_q             <= pc_plus4;
                            state_q          <= StFetch;
                        end
                    end
                    default: state_q <= StFetch;
                endcase
            end
        end
    end

    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed bench for if_stage_unit; memory returns (address ^ 0xDEAD0000) so every
// expected instruction word is written out by hand below.
module tb_if_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_detected;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    if_stage_unit dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc4"}, if_id_pc_plus4, pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1;
        hazard_detected = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        imem_ready = 1'b1;
        step();
        step();
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
        check("reset.addr", imem_addr, 32'h0);
        check("reset.stall", {16'd0, stall_cnt}, 32'd0);
        check("reset.flush", {16'd0, flush_cnt}, 32'd0);

        // Zero-wait sequential fetch
        rst = 1'b0;
        #1;
        check("seq.req", {31'd0, imem_req}, 32'd1);
        step();
        check_ifid("seq0", 32'hDEAD_0000, 32'h4, 1'b1);
        check("seq0.addr", imem_addr, 32'h4);
        step();
        check_ifid("seq1", 32'hDEAD_0004, 32'h8, 1'b1);
        step();
        check_ifid("seq2", 32'hDEAD_0008, 32'hC, 1'b1);
        step();
        check_ifid("seq3", 32'hDEAD_000C, 32'h10, 1'b1);
        check("seq3.addr", imem_addr, 32'h10);

        // Memory not ready for three cycles at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait.instr", if_id_instr, 32'h0);
            check("wait.valid", {31'd0, if_id_valid}, 32'd0);
            check("wait.addr", imem_addr, 32'h10);
        end
        imem_ready = 1'b1;
        step();
        check_ifid("wait.done", 32'hDEAD_0010, 32'h14, 1'b1);
        step();
        check_ifid("wait.next", 32'hDEAD_0014, 32'h18, 1'b1);
        step();
        step();
        check_ifid("pre.hold", 32'hDEAD_001C, 32'h20, 1'b1);
        check("pre.hold.addr", imem_addr, 32'h20);

        // Freeze for two cycles while 0x20 transfers
        hazard_detected = 1'b1;
        step();
        check_ifid("hold1", 32'hDEAD_001C, 32'h20, 1'b1);
        check("hold1.req", {31'd0, imem_req}, 32'd0);
        check("hold1.stall", {16'd0, stall_cnt}, 32'd1);
        step();
        check_ifid("hold2", 32'hDEAD_001C, 32'h20, 1'b1);
        check("hold2.stall", {16'd0, stall_cnt}, 32'd2);
        hazard_detected = 1'b0;
        step();
        check_ifid("release", 32'hDEAD_0020, 32'h24, 1'b1);
        check("release.addr", imem_addr, 32'h24);
        check("release.req", {31'd0, imem_req}, 32'd1);
        step();
        check_ifid("after", 32'hDEAD_0024, 32'h28, 1'b1);

        // Taken branch to unaligned 0x103
        branch_taken = 1'b1;
        branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        check("br.addr", imem_addr, 32'h100);
        check("br.valid", {31'd0, if_id_valid}, 32'd0);
        check("br.instr", if_id_instr, 32'h0);
        check("br.flush", {16'd0, flush_cnt}, 32'd1);
        step();
        check_ifid("br.tgt", 32'hDEAD_0100, 32'h104, 1'b1);

        // Branch together with hazard: branch ignored, freeze applied
        branch_taken = 1'b1;
        branch_target = 32'h200;
        hazard_detected = 1'b1;
        step();
        branch_taken = 1'b0;
        hazard_detected = 1'b0;
        check("bh.addr", imem_addr, 32'h104);
        check("bh.stall", {16'd0, stall_cnt}, 32'd3);
        check("bh.flush", {16'd0, flush_cnt}, 32'd1);
        check_ifid("bh.ifid", 32'hDEAD_0100, 32'h104, 1'b1);
        step();
        check_ifid("bh.rel", 32'hDEAD_0104, 32'h108, 1'b1);

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap.flush", {16'd0, flush_cnt}, 32'd2);
        step();
        check_ifid("wrap", 32'h2152_FFFC, 32'h0, 1'b1);
        check("wrap.next", imem_addr, 32'h0);

        // Reset while HELD
        hazard_detected = 1'b1;
        step();
        check("held.req", {31'd0, imem_req}, 32'd0);
        check("held.stall", {16'd0, stall_cnt}, 32'd4);
        rst = 1'b1;
        #1;
        check_ifid("rst.held", 32'h0, 32'h0, 1'b0);
        check("rst.addr", imem_addr, 32'h0);
        check("rst.stall", {16'd0, stall_cnt}, 32'd0);
        check("rst.flush", {16'd0, flush_cnt}, 32'd0);
        hazard_detected = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rst.req", {31'd0, imem_req}, 32'd1);
        step();
        check_ifid("rst.first", 32'hDEAD_0000, 32'h4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
